cam_assoc_array: RTL and testbench

- Parametrised fully-associative tag/data CAM with per-entry valid bits, registered lookup, insert-with-update, invalidate-by-tag, flush-all and tree-PLRU victim selection.
- Successor to the fixed 64-entry CAM array.
- Sits behind the TLBs and the small fully-associative caches of the pipeline. The pipeline supplies a tag and receives hit, data and index one cycle later.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_plru.sv | 55 +++++
 rtl/cam_assoc_array.sv | 181 ++++++++++++++++++
 tb/tb_cam_assoc_array.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the associative array: command encoding and the
// single-cycle command arbitration used by the top level.
package cam_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INVAL = 2'd2,
    OP_FLUSH = 2'd3
  } cam_op_e;

  // Only one state-changing command is honoured per cycle; the rest are dropped.
  function automatic cam_op_e cam_op_select(input logic flush, input logic inval,
                                            input logic write);
    if (flush) return OP_FLUSH;
    if (inval) return OP_INVAL;
    if (write) return OP_WRITE;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/cam_plru.sv
// Tree pseudo-LRU over DEPTH leaves: DEPTH-1 heap-ordered node bits, a promote
// port that points every node on the leaf's path away from it, and the victim walk.
module cam_plru #(
  parameter  int DEPTH     = 64,
  localparam int IDX_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 promote,
  input  logic [IDX_WIDTH-1:0] promote_idx,
  input  logic                 clear,
  output logic [IDX_WIDTH-1:0] victim_idx
);

  localparam int NODES = DEPTH - 1;

  // Node n has children 2n+1 (bit=0 side) and 2n+2 (bit=1 side); a bit names the victim side.
  logic [NODES-1:0] tree_q;
  logic [NODES-1:0] tree_d;
  logic [DEPTH-1:0] leaf_sel;

  for (genvar gi = 0; gi < NODES; gi++) begin : g_node
    localparam int LVL = $clog2(gi + 2) - 1;
    localparam int POS = gi + 1 - (1 << LVL);
    logic on_path;
    assign on_path    = (promote_idx >> (IDX_WIDTH - LVL)) == IDX_WIDTH'(POS);
    assign tree_d[gi] = clear ? 1'b0 :
                        (promote && on_path) ? ~promote_idx[IDX_WIDTH-1-LVL] :
                        tree_q[gi];
  end

  // A leaf is the victim when every node above it points toward it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_leaf
    logic [IDX_WIDTH-1:0] step_ok;
    for (genvar gl = 0; gl < IDX_WIDTH; gl++) begin : g_lvl
      localparam int NODE = (1 << gl) - 1 + (gi >> (IDX_WIDTH - gl));
      localparam bit DIR  = ((gi >> (IDX_WIDTH - 1 - gl)) & 1) != 0;
      assign step_ok[gl] = (tree_q[NODE] == DIR);
    end
    assign leaf_sel[gi] = &step_ok;
  end

  always_comb begin
    victim_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (leaf_sel[i]) victim_idx = IDX_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tree_q <= '0;
    else     tree_q <= tree_d;
  end

endmodule

// File: rtl/cam_assoc_array.sv
// Fully-associative tag/data array with registered lookup, insert-or-update,
// invalidate-by-tag, flush, and tree-PLRU replacement when no entry is free.
module cam_assoc_array
  import cam_pkg::*;
#(
  parameter  int TAG_WIDTH  = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 64,
  localparam int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] hit_data,
  output logic [IDX_WIDTH-1:0]  hit_idx,
  input  logic                  write,
  input  logic [TAG_WIDTH-1:0]  write_tag,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  inval,
  input  logic [TAG_WIDTH-1:0]  inval_tag,
  input  logic                  flush,
  output logic                  evict_valid,
  output logic [TAG_WIDTH-1:0]  evict_tag,
  output logic [DATA_WIDTH-1:0] evict_data,
  output logic                  full
);

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  function automatic logic [IDX_WIDTH-1:0] lowest_set(input logic [DEPTH-1:0] v);
    logic [IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_WIDTH'(i);
    end
    return idx;
  endfunction

  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      valid_d;
  logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [DEPTH-1:0] lk_match;
  logic [DEPTH-1:0] wr_match;
  logic [DEPTH-1:0] iv_match;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign lk_match[gi] = valid_q[gi] && (tag_q[gi] == lookup_tag);
    assign wr_match[gi] = valid_q[gi] && (tag_q[gi] == write_tag);
    assign iv_match[gi] = valid_q[gi] && (tag_q[gi] == inval_tag);
  end

  cam_op_e              op;
  logic                 lk_any;
  logic                 wr_any;
  logic                 iv_any;
  logic                 free_any;
  logic [IDX_WIDTH-1:0] lk_idx;
  logic [IDX_WIDTH-1:0] wr_hit_idx;
  logic [IDX_WIDTH-1:0] iv_idx;
  logic [IDX_WIDTH-1:0] free_idx;
  logic [IDX_WIDTH-1:0] victim_idx;
  logic [IDX_WIDTH-1:0] wr_idx;
  entry_t               victim_e;
  logic                 evict_now;
  logic                 plru_promote;
  logic [IDX_WIDTH-1:0] plru_idx;

  assign op         = cam_op_select(flush, inval, write);
  assign lk_any     = |lk_match;
  assign wr_any     = |wr_match;
  assign iv_any     = |iv_match;
  assign free_any   = ~&valid_q;
  assign lk_idx     = lowest_set(lk_match);
  assign wr_hit_idx = lowest_set(wr_match);
  assign iv_idx     = lowest_set(iv_match);
  assign free_idx   = lowest_set(~valid_q);
  assign full       = &valid_q;

  always_comb begin
    wr_idx = victim_idx;
    if (wr_any)        wr_idx = wr_hit_idx;
    else if (free_any) wr_idx = free_idx;
  end

  assign victim_e  = '{valid: valid_q[victim_idx], tag: tag_q[victim_idx],
                       data: data_q[victim_idx]};
  assign evict_now = (op == OP_WRITE) && !wr_any && !free_any && victim_e.valid;

  // Write promotion overrides lookup promotion when both occur in one cycle.
  assign plru_promote = (op == OP_WRITE) || (lookup && lk_any);
  assign plru_idx     = (op == OP_WRITE) ? wr_idx : lk_idx;

  cam_plru #(
    .DEPTH(DEPTH)
  ) u_plru (
    .clk        (clk),
    .rst        (rst),
    .promote    (plru_promote),
    .promote_idx(plru_idx),
    .clear      (op == OP_FLUSH),
    .victim_idx (victim_idx)
  );

  always_comb begin
    valid_d = valid_q;
    case (op)
      OP_FLUSH: valid_d = '0;
      OP_INVAL: if (iv_any) valid_d[iv_idx] = 1'b0;
      OP_WRITE: valid_d[wr_idx] = 1'b1;
      default:  valid_d = valid_q;
    endcase
  end

  logic                  hit_d,  hit_q;
  logic [DATA_WIDTH-1:0] hit_data_d, hit_data_q;
  logic [IDX_WIDTH-1:0]  hit_idx_d, hit_idx_q;
  logic                  evict_valid_q;
  logic [TAG_WIDTH-1:0]  evict_tag_d, evict_tag_q;
  logic [DATA_WIDTH-1:0] evict_data_d, evict_data_q;

  // Lookup samples pre-edge contents, so same-cycle writes/flushes are invisible to it.
  always_comb begin
    hit_d        = lookup && lk_any;
    hit_data_d   = '0;
    hit_idx_d    = '0;
    evict_tag_d  = evict_tag_q;
    evict_data_d = evict_data_q;
    if (hit_d) begin
      hit_data_d = data_q[lk_idx];
      hit_idx_d  = lk_idx;
    end
    if (evict_now) begin
      evict_tag_d  = victim_e.tag;
      evict_data_d = victim_e.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      hit_q         <= 1'b0;
      hit_data_q    <= '0;
      hit_idx_q     <= '0;
      evict_valid_q <= 1'b0;
      evict_tag_q   <= '0;
      evict_data_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      hit_q         <= hit_d;
      hit_data_q    <= hit_data_d;
      hit_idx_q     <= hit_idx_d;
      evict_valid_q <= evict_now;
      evict_tag_q   <= evict_tag_d;
      evict_data_q  <= evict_data_d;
    end
  end

  // Payload storage carries no reset; contents are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (op == OP_WRITE) begin
      tag_q[wr_idx]  <= write_tag;
      data_q[wr_idx] <= write_data;
    end
  end

  assign hit         = hit_q;
  assign hit_data    = hit_data_q;
  assign hit_idx     = hit_idx_q;
  assign evict_valid = evict_valid_q;
  assign evict_tag   = evict_tag_q;
  assign evict_data  = evict_data_q;

endmodule

// File: tb/tb_cam_assoc_array.sv
// Directed scoreboard bench for a 4-entry array: the driver queues expected
// responses, a negedge monitor pops and compares them when they fall due.
module tb_cam_assoc_array;

  localparam int TW = 16;
  localparam int DW = 16;
  localparam int DP = 4;
  localparam int IW = 2;

  localparam int K_LOOKUP  = 0;
  localparam int K_EVICT   = 1;
  localparam int K_NOEVICT = 2;
  localparam int K_FULL    = 3;
  localparam int K_ZERO    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lookup = 1'b0;
  logic [TW-1:0] lookup_tag = '0;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic [IW-1:0] hit_idx;
  logic          write = 1'b0;
  logic [TW-1:0] write_tag = '0;
  logic [DW-1:0] write_data = '0;
  logic          inval = 1'b0;
  logic [TW-1:0] inval_tag = '0;
  logic          flush = 1'b0;
  logic          evict_valid;
  logic [TW-1:0] evict_tag;
  logic [DW-1:0] evict_data;
  logic          full;

  cam_assoc_array #(
    .TAG_WIDTH (TW),
    .DATA_WIDTH(DW),
    .DEPTH     (DP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lookup     (lookup),
    .lookup_tag (lookup_tag),
    .hit        (hit),
    .hit_data   (hit_data),
    .hit_idx    (hit_idx),
    .write      (write),
    .write_tag  (write_tag),
    .write_data (write_data),
    .inval      (inval),
    .inval_tag  (inval_tag),
    .flush      (flush),
    .evict_valid(evict_valid),
    .evict_tag  (evict_tag),
    .evict_data (evict_data),
    .full       (full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    int            kind;
    logic          h;
    logic [TW-1:0] t;
    logic [DW-1:0] d;
    logic [IW-1:0] i;
  } rec_t;

  rec_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endfunction

  function automatic void push(string nm, int kind, logic h, logic [TW-1:0] t,
                               logic [DW-1:0] d, logic [IW-1:0] i);
    rec_t r;
    r.due  = cyc + 1;
    r.kind = kind;
    r.h    = h;
    r.t    = t;
    r.d    = d;
    r.i    = i;
    exp_q.push_back(r);
    name_q.push_back(nm);
  endfunction

  function automatic void exp_lk(string nm, logic h, logic [DW-1:0] d, logic [IW-1:0] i);
    push(nm, K_LOOKUP, h, '0, d, i);
  endfunction

  function automatic void exp_full(string nm, logic f);
    push(nm, K_FULL, f, '0, '0, '0);
  endfunction

  task automatic drv(input logic lk, input logic [TW-1:0] lt, input logic wr,
                     input logic [TW-1:0] wt, input logic [DW-1:0] wd,
                     input logic iv, input logic [TW-1:0] it, input logic fl);
    @(negedge clk);
    #1;
    lookup     = lk;
    lookup_tag = lt;
    write      = wr;
    write_tag  = wt;
    write_data = wd;
    inval      = iv;
    inval_tag  = it;
    flush      = fl;
  endtask

  task automatic idle();
    drv(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_lookup(input logic [TW-1:0] tag);
    drv(1'b1, tag, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_write(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    drv(1'b0, '0, 1'b1, tag, data, 1'b0, '0, 1'b0);
  endtask

  task automatic fill();
    for (int k = 0; k < DP; k++) begin
      do_write(16'h0010 + 16'(k), 16'h00A0 + 16'(k));
      push($sformatf("fill%0d_noevict", k), K_NOEVICT, 1'b0, '0, '0, '0);
      exp_full($sformatf("fill%0d_full", k), k == DP - 1);
    end
  endtask

  // Monitor: compare every expectation that falls due on this cycle.
  initial begin
    rec_t  r;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        r  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, ".due"}, 32'(cyc), 32'(r.due));
        case (r.kind)
          K_LOOKUP: begin
            chk({nm, ".hit"}, 32'(hit), 32'(r.h));
            chk({nm, ".hit_data"}, 32'(hit_data), 32'(r.d));
            chk({nm, ".hit_idx"}, 32'(hit_idx), 32'(r.i));
          end
          K_EVICT: begin
            chk({nm, ".evict_valid"}, 32'(evict_valid), 32'd1);
            chk({nm, ".evict_tag"}, 32'(evict_tag), 32'(r.t));
            chk({nm, ".evict_data"}, 32'(evict_data), 32'(r.d));
          end
          K_NOEVICT: chk({nm, ".evict_valid"}, 32'(evict_valid), 32'd0);
          K_FULL:    chk({nm, ".full"}, 32'(full), 32'(r.h));
          default: begin
            chk({nm, ".hit"}, 32'(hit), 32'd0);
            chk({nm, ".hit_data"}, 32'(hit_data), 32'd0);
            chk({nm, ".hit_idx"}, 32'(hit_idx), 32'd0);
            chk({nm, ".evict_valid"}, 32'(evict_valid), 32'd0);
            chk({nm, ".evict_tag"}, 32'(evict_tag), 32'd0);
            chk({nm, ".evict_data"}, 32'(evict_data), 32'd0);
            chk({nm, ".full"}, 32'(full), 32'd0);
          end
        endcase
        $display("[cyc %0d] %s compared", cyc, nm);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    push("reset_outputs", K_ZERO, 1'b0, '0, '0, '0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    do_lookup(16'h0010);
    exp_lk("empty_miss", 1'b0, '0, '0);
    exp_full("empty_full", 1'b0);

    fill();
    do_lookup(16'h0012);
    exp_lk("lookup_12", 1'b1, 16'h00A2, 2'd2);
    exp_full("full_after_fill", 1'b1);
    idle();
    exp_lk("hit_drops", 1'b0, '0, '0);

    // Fresh fill so the replacement order is set only by the lookups below.
    drv(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    exp_full("flush_clears", 1'b0);
    fill();
    do_lookup(16'h0010);
    exp_lk("lookup_10", 1'b1, 16'h00A0, 2'd0);
    do_lookup(16'h0011);
    exp_lk("lookup_11", 1'b1, 16'h00A1, 2'd1);
    do_write(16'h0020, 16'h00B0);
    push("evict_12", K_EVICT, 1'b1, 16'h0012, 16'h00A2, '0);
    idle();
    push("evict_one_cycle", K_NOEVICT, 1'b0, '0, '0, '0);
    do_lookup(16'h0020);
    exp_lk("lookup_20", 1'b1, 16'h00B0, 2'd2);

    do_write(16'h0011, 16'h00FF);
    push("update_noevict", K_NOEVICT, 1'b0, '0, '0, '0);
    do_lookup(16'h0011);
    exp_lk("lookup_11_upd", 1'b1, 16'h00FF, 2'd1);

    drv(1'b0, '0, 1'b1, 16'h0030, 16'h0077, 1'b1, 16'h0013, 1'b0);
    exp_full("inval_full", 1'b0);
    push("inval_drops_write", K_NOEVICT, 1'b0, '0, '0, '0);
    do_lookup(16'h0030);
    exp_lk("lookup_30_miss", 1'b0, '0, '0);
    do_lookup(16'h0013);
    exp_lk("lookup_13_miss", 1'b0, '0, '0);

    drv(1'b1, 16'h0010, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    exp_lk("lookup_with_flush", 1'b1, 16'h00A0, 2'd0);
    exp_full("flush_full", 1'b0);
    do_lookup(16'h0010);
    exp_lk("lookup_after_flush", 1'b0, '0, '0);

    do_write(16'h0010, 16'h00C0);
    do_lookup(16'h0010);
    push("reset_aborts_lookup", K_ZERO, 1'b0, '0, '0, '0);
    #2;
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    do_lookup(16'h0010);
    exp_lk("lookup_after_reset", 1'b0, '0, '0);
    idle();

    for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(negedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
